// File: rtl/id_stage_pipe.sv
// RV32I decode stage: registers decoded fields between IF and EX behind valid/ready
// handshakes, with flush, illegal-encoding detection and a local JAL redirect.
package id_stage_pipe_pkg;
    localparam logic [7:0] ID_NONE   = 8'd0;
    localparam logic [7:0] ID_LUI    = 8'd1;
    localparam logic [7:0] ID_AUIPC  = 8'd2;
    localparam logic [7:0] ID_JAL    = 8'd3;
    localparam logic [7:0] ID_JALR   = 8'd4;
    localparam logic [7:0] ID_BEQ    = 8'd5;
    localparam logic [7:0] ID_BNE    = 8'd6;
    localparam logic [7:0] ID_BLT    = 8'd7;
    localparam logic [7:0] ID_BGE    = 8'd8;
    localparam logic [7:0] ID_BLTU   = 8'd9;
    localparam logic [7:0] ID_BGEU   = 8'd10;
    localparam logic [7:0] ID_LB     = 8'd11;
    localparam logic [7:0] ID_LH     = 8'd12;
    localparam logic [7:0] ID_LW     = 8'd13;
    localparam logic [7:0] ID_LBU    = 8'd14;
    localparam logic [7:0] ID_LHU    = 8'd15;
    localparam logic [7:0] ID_SB     = 8'd16;
    localparam logic [7:0] ID_SH     = 8'd17;
    localparam logic [7:0] ID_SW     = 8'd18;
    localparam logic [7:0] ID_ADDI   = 8'd19;
    localparam logic [7:0] ID_SLTI   = 8'd20;
    localparam logic [7:0] ID_SLTIU  = 8'd21;
    localparam logic [7:0] ID_XORI   = 8'd22;
    localparam logic [7:0] ID_ORI    = 8'd23;
    localparam logic [7:0] ID_ANDI   = 8'd24;
    localparam logic [7:0] ID_SLLI   = 8'd25;
    localparam logic [7:0] ID_SRLI   = 8'd26;
    localparam logic [7:0] ID_SRAI   = 8'd27;
    localparam logic [7:0] ID_ADD    = 8'd28;
    localparam logic [7:0] ID_SUB    = 8'd29;
    localparam logic [7:0] ID_SLL    = 8'd30;
    localparam logic [7:0] ID_SLT    = 8'd31;
    localparam logic [7:0] ID_SLTU   = 8'd32;
    localparam logic [7:0] ID_XOR    = 8'd33;
    localparam logic [7:0] ID_SRL    = 8'd34;
    localparam logic [7:0] ID_SRA    = 8'd35;
    localparam logic [7:0] ID_OR     = 8'd36;
    localparam logic [7:0] ID_AND    = 8'd37;
    localparam logic [7:0] ID_FENCE  = 8'd38;
    localparam logic [7:0] ID_ECALL  = 8'd39;
    localparam logic [7:0] ID_EBREAK = 8'd40;
endpackage

module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int INSTID_W  = 8,
    parameter int PC_W      = 32,
    parameter bit EN_SYSTEM = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    input  logic [PC_W-1:0]     if_pc,
    output logic                id_ready,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                id_valid,
    output logic [PC_W-1:0]     id_pc,
    output logic [4:0]          id_rs1,
    output logic [4:0]          id_rs2,
    output logic [4:0]          id_rd,
    output logic                id_rs1_en,
    output logic                id_rs2_en,
    output logic                id_rd_en,
    output logic [31:0]         id_imm,
    output logic [INSTID_W-1:0] id_instID,
    output logic                id_illegal,
    output logic                jmp_vld,
    output logic [PC_W-1:0]     jmp_addr
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;
    logic [7:0]  d_code;
    logic [31:0] d_imm;
    logic        use_rs1, use_rs2, use_rd;
    logic        d_rs1_en, d_rs2_en, d_rd_en, d_illegal, d_jal;
    logic        accept;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign funct7 = if_inst[31:25];
    assign i_imm  = {{20{if_inst[31]}}, if_inst[31:20]};
    assign s_imm  = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign b_imm  = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign u_imm  = {if_inst[31:12], 12'b0};
    assign j_imm  = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
    assign sh_imm = {27'b0, if_inst[24:20]};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        d_code  = ID_NONE;
        d_imm   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OP_LUI:   begin d_code = ID_LUI;   d_imm = u_imm; use_rd = 1'b1; end
            OP_AUIPC: begin d_code = ID_AUIPC; d_imm = u_imm; use_rd = 1'b1; end
            OP_JAL:   begin d_code = ID_JAL;   d_imm = j_imm; use_rd = 1'b1; end
            OP_JALR: begin
                if (funct3 == 3'b000) d_code = ID_JALR;
                d_imm = i_imm; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000: d_code = ID_BEQ;
                    3'b001: d_code = ID_BNE;
                    3'b100: d_code = ID_BLT;
                    3'b101: d_code = ID_BGE;
                    3'b110: d_code = ID_BLTU;
                    3'b111: d_code = ID_BGEU;
                    default: d_code = ID_NONE;
                endcase
                d_imm = b_imm; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000: d_code = ID_LB;
                    3'b001: d_code = ID_LH;
                    3'b010: d_code = ID_LW;
                    3'b100: d_code = ID_LBU;
                    3'b101: d_code = ID_LHU;
                    default: d_code = ID_NONE;
                endcase
                d_imm = i_imm; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: d_code = ID_SB;
                    3'b001: d_code = ID_SH;
                    3'b010: d_code = ID_SW;
                    default: d_code = ID_NONE;
                endcase
                d_imm = s_imm; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM: begin
                case (funct3)
                    3'b000: d_code = ID_ADDI;
                    3'b010: d_code = ID_SLTI;
                    3'b011: d_code = ID_SLTIU;
                    3'b100: d_code = ID_XORI;
                    3'b110: d_code = ID_ORI;
                    3'b111: d_code = ID_ANDI;
                    3'b001: if (funct7 == F7_BASE) d_code = ID_SLLI;
                    default: begin
                        if (funct7 == F7_BASE)     d_code = ID_SRLI;
                        else if (funct7 == F7_ALT) d_code = ID_SRAI;
                    end
                endcase
                // Shift-immediates carry only the shamt; funct7 is not part of the value.
                d_imm   = (funct3[1:0] == 2'b01) ? sh_imm : i_imm;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_REG: begin
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: d_code = ID_ADD;
                    {F7_ALT,  3'b000}: d_code = ID_SUB;
                    {F7_BASE, 3'b001}: d_code = ID_SLL;
                    {F7_BASE, 3'b010}: d_code = ID_SLT;
                    {F7_BASE, 3'b011}: d_code = ID_SLTU;
                    {F7_BASE, 3'b100}: d_code = ID_XOR;
                    {F7_BASE, 3'b101}: d_code = ID_SRL;
                    {F7_ALT,  3'b101}: d_code = ID_SRA;
                    {F7_BASE, 3'b110}: d_code = ID_OR;
                    {F7_BASE, 3'b111}: d_code = ID_AND;
                    default:           d_code = ID_NONE;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_FENCE: if (EN_SYSTEM && funct3 == 3'b000) d_code = ID_FENCE;
            OP_SYSTEM: begin
                if (EN_SYSTEM && funct3 == 3'b000 && if_inst[19:15] == 5'd0 && if_inst[11:7] == 5'd0) begin
                    if (if_inst[31:20] == 12'h000)      d_code = ID_ECALL;
                    else if (if_inst[31:20] == 12'h001) d_code = ID_EBREAK;
                end
            end
            default: d_code = ID_NONE;
        endcase
        // Illegal encodings expose no operands and no immediate.
        if (d_code == ID_NONE) begin
            d_imm   = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
        end
    end

    assign d_rs1_en  = use_rs1;
    assign d_rs2_en  = use_rs2;
    assign d_rd_en   = use_rd && (if_inst[11:7] != 5'd0);
    assign d_illegal = (d_code == ID_NONE);
    assign d_jal     = (opcode == OP_JAL);

    assign id_ready = !id_valid || ex_ready;
    assign accept   = if_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so outputs read as zero until the first accept.
            id_valid   <= 1'b0;
            jmp_vld    <= 1'b0;
            id_pc      <= '0;
            id_rs1     <= '0;
            id_rs2     <= '0;
            id_rd      <= '0;
            id_rs1_en  <= 1'b0;
            id_rs2_en  <= 1'b0;
            id_rd_en   <= 1'b0;
            id_imm     <= '0;
            id_instID  <= '0;
            id_illegal <= 1'b0;
            jmp_addr   <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            jmp_vld  <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            jmp_vld    <= d_jal;
            id_pc      <= if_pc;
            id_rs1     <= if_inst[19:15];
            id_rs2     <= if_inst[24:20];
            id_rd      <= if_inst[11:7];
            id_rs1_en  <= d_rs1_en;
            id_rs2_en  <= d_rs2_en;
            id_rd_en   <= d_rd_en;
            id_imm     <= d_imm;
            id_instID  <= INSTID_W'(d_code);
            id_illegal <= d_illegal;
            jmp_addr   <= if_pc + j_imm[PC_W-1:0];
        end else begin
            jmp_vld <= 1'b0;
            if (ex_ready) id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a table-driven RV32I reference model predicts
// each accepted word; a negedge monitor compares whatever the stage presents.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    typedef enum {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_N} fmt_t;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [7:0]  code;
        fmt_t        fmt;
    } op_t;
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  en;
        logic [31:0] imm;
        logic [7:0]  code;
        logic        illegal;
        logic        jal;
        logic [31:0] jaddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, flush, ex_ready;
    logic [31:0] if_inst, if_pc;
    logic        id_ready, id_valid;
    logic [31:0] id_pc, id_imm, jmp_addr;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_en, id_rs2_en, id_rd_en, id_illegal, jmp_vld;
    logic [7:0]  id_instID;

    op_t         ops[$];
    exp_t        exp_q[$];
    logic [31:0] exp_delivered[$];
    logic [31:0] act_delivered[$];
    logic        exp_jmp = 1'b0;
    int          checks = 0;
    int          failures = 0;

    id_stage_pipe #(.INSTID_W(8), .PC_W(32), .EN_SYSTEM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd_en(id_rd_en),
        .id_imm(id_imm), .id_instID(id_instID), .id_illegal(id_illegal),
        .jmp_vld(jmp_vld), .jmp_addr(jmp_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp_v);
        end
    endtask

    function automatic void add_op(input logic [31:0] mask, input logic [31:0] match,
                                   input logic [7:0] code, input fmt_t fmt);
        op_t o;
        o.mask = mask; o.match = match; o.code = code; o.fmt = fmt;
        ops.push_back(o);
    endfunction

    task automatic build_table();
        logic [31:0] m3, m7;
        m3 = 32'h0000_707F;
        m7 = 32'hFE00_707F;
        add_op(32'h7F, 32'h37, ID_LUI, F_U);
        add_op(32'h7F, 32'h17, ID_AUIPC, F_U);
        add_op(32'h7F, 32'h6F, ID_JAL, F_J);
        add_op(m3, 32'h67, ID_JALR, F_I);
        add_op(m3, 32'h0063, ID_BEQ, F_B);  add_op(m3, 32'h1063, ID_BNE, F_B);
        add_op(m3, 32'h4063, ID_BLT, F_B);  add_op(m3, 32'h5063, ID_BGE, F_B);
        add_op(m3, 32'h6063, ID_BLTU, F_B); add_op(m3, 32'h7063, ID_BGEU, F_B);
        add_op(m3, 32'h0003, ID_LB, F_I);   add_op(m3, 32'h1003, ID_LH, F_I);
        add_op(m3, 32'h2003, ID_LW, F_I);   add_op(m3, 32'h4003, ID_LBU, F_I);
        add_op(m3, 32'h5003, ID_LHU, F_I);
        add_op(m3, 32'h0023, ID_SB, F_S);   add_op(m3, 32'h1023, ID_SH, F_S);
        add_op(m3, 32'h2023, ID_SW, F_S);
        add_op(m3, 32'h0013, ID_ADDI, F_I); add_op(m3, 32'h2013, ID_SLTI, F_I);
        add_op(m3, 32'h3013, ID_SLTIU, F_I); add_op(m3, 32'h4013, ID_XORI, F_I);
        add_op(m3, 32'h6013, ID_ORI, F_I);  add_op(m3, 32'h7013, ID_ANDI, F_I);
        add_op(m7, 32'h0000_1013, ID_SLLI, F_SH);
        add_op(m7, 32'h0000_5013, ID_SRLI, F_SH);
        add_op(m7, 32'h4000_5013, ID_SRAI, F_SH);
        add_op(m7, 32'h0000_0033, ID_ADD, F_R); add_op(m7, 32'h4000_0033, ID_SUB, F_R);
        add_op(m7, 32'h0000_1033, ID_SLL, F_R); add_op(m7, 32'h0000_2033, ID_SLT, F_R);
        add_op(m7, 32'h0000_3033, ID_SLTU, F_R); add_op(m7, 32'h0000_4033, ID_XOR, F_R);
        add_op(m7, 32'h0000_5033, ID_SRL, F_R); add_op(m7, 32'h4000_5033, ID_SRA, F_R);
        add_op(m7, 32'h0000_6033, ID_OR, F_R);  add_op(m7, 32'h0000_7033, ID_AND, F_R);
        add_op(m3, 32'h0F, ID_FENCE, F_N);
        add_op(32'hFFFF_FFFF, 32'h0000_0073, ID_ECALL, F_N);
        add_op(32'hFFFF_FFFF, 32'h0010_0073, ID_EBREAK, F_N);
    endtask

    // Reference decode: first table hit gives the ID and format; the format alone
    // determines the immediate layout and which operands are used.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        fmt_t f;
        bit   hit;
        f = F_N; hit = 1'b0;
        e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        e.code = ID_NONE; e.imm = '0; e.en = '0;
        foreach (ops[k]) begin
            if (!hit && (inst & ops[k].mask) == ops[k].match) begin
                hit = 1'b1; f = ops[k].fmt; e.code = ops[k].code;
            end
        end
        e.illegal = !hit;
        if (hit) begin
            case (f)
                F_I:  e.imm = {{20{inst[31]}}, inst[31:20]};
                F_SH: e.imm = 32'(inst[24:20]);
                F_S:  e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                F_B:  e.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                F_U:  e.imm = {inst[31:12], 12'h000};
                F_J:  e.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                default: e.imm = '0;
            endcase
            e.en[2] = f inside {F_R, F_I, F_SH, F_S, F_B};
            e.en[1] = f inside {F_R, F_S, F_B};
            e.en[0] = (f inside {F_R, F_I, F_SH, F_U, F_J}) && (inst[11:7] != 5'd0);
        end
        e.jal   = (e.code == ID_JAL);
        e.jaddr = pc + e.imm;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned sel, k;
        logic [31:0] w;
        sel = $urandom_range(0, 11);
        k   = $urandom_range(0, ops.size() - 1);
        if (sel == 2) k = 2;
        w = ops[k].match | ($urandom() & ~ops[k].mask);
        if (sel == 0)      w = $urandom();
        else if (sel == 1) w[1:0] = 2'($urandom_range(0, 2));
        else if (sel == 3) w[31:25] = 7'($urandom());
        return w;
    endfunction

    // Expected-side process: decides each edge's transfer/accept and feeds the scoreboard.
    initial begin
        exp_t e;
        bit   acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || flush) begin
                exp_q.delete();
                exp_jmp = 1'b0;
            end else begin
                acc = if_valid && (exp_q.size() == 0 || ex_ready);
                if (exp_q.size() != 0 && ex_ready) begin
                    exp_delivered.push_back(exp_q[0].pc);
                    void'(exp_q.pop_front());
                end
                exp_jmp = 1'b0;
                if (acc) begin
                    e = model(if_inst, if_pc);
                    exp_q.push_back(e);
                    exp_jmp = e.jal;
                end
            end
        end
    end

    // Monitor: compares the presented instruction against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
                check("id_ready", 64'(id_ready), 64'(exp_q.size() == 0 || ex_ready));
                check("jmp_vld", 64'(jmp_vld), 64'(exp_jmp));
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("id_pc", 64'(id_pc), 64'(e.pc));
                    check("regs", 64'({id_rs1, id_rs2, id_rd}), 64'({e.rs1, e.rs2, e.rd}));
                    check("enables", 64'({id_rs1_en, id_rs2_en, id_rd_en}), 64'(e.en));
                    check("id_imm", 64'(id_imm), 64'(e.imm));
                    check("id_instID", 64'(id_instID), 64'(e.code));
                    check("id_illegal", 64'(id_illegal), 64'(e.illegal));
                    if (exp_jmp) check("jmp_addr", 64'(jmp_addr), 64'(e.jaddr));
                end
                if (id_valid && ex_ready && !flush) act_delivered.push_back(id_pc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic er, input logic fl);
        if_valid = v; if_inst = inst; if_pc = pc; ex_ready = er; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] inst, pc;
        logic        v, er, fl;
        logic        er_pat[4];
        bit          acc;
        int          pulses, idx, cyc, n;

        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b0; flush = 1'b0;
        build_table();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({id_valid, jmp_vld, id_pc, id_imm}), 64'd0);
        check("reset_fields", 64'({id_instID, id_illegal, id_rs1, id_rs2, id_rd, jmp_addr}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        check("idle_after_reset", 64'({id_valid, id_imm, id_instID}), 64'd0);

        // ADDI x1,x0,5
        drive(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        check("addi_valid", 64'(id_valid), 64'd1);
        check("addi_rd_rs1", 64'({id_rd, id_rs1}), 64'({5'd1, 5'd0}));
        check("addi_imm", 64'(id_imm), 64'd5);
        check("addi_id", 64'(id_instID), 64'(ID_ADDI));
        check("addi_en", 64'({id_rd_en, id_rs2_en}), 64'(2'b10));

        // JAL x1,+8 at 0x100, then held for three cycles
        drive(1'b1, 32'h0080_00EF, 32'h100, 1'b1, 1'b0);
        check("jal_pulse", 64'(jmp_vld), 64'd1);
        check("jal_target", 64'(jmp_addr), 64'h108);
        check("jal_imm", 64'(id_imm), 64'd8);
        pulses = 0;
        repeat (3) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            pulses += int'(jmp_vld);
        end
        check("jal_no_repulse", 64'(pulses), 64'd0);
        check("jal_held_id", 64'(id_instID), 64'(ID_JAL));
        idle(1);

        drive(1'b1, 32'h4020_81B3, 32'h200, 1'b1, 1'b0);
        check("sub_id", 64'(id_instID), 64'(ID_SUB));
        check("sub_rs", 64'({id_rs1, id_rs2}), 64'({5'd1, 5'd2}));
        drive(1'b1, 32'h4032_D293, 32'h204, 1'b1, 1'b0);
        check("srai_id", 64'(id_instID), 64'(ID_SRAI));
        check("srai_imm", 64'(id_imm), 64'd3);
        drive(1'b1, 32'h0020_A223, 32'h208, 1'b1, 1'b0);
        check("sw_id", 64'(id_instID), 64'(ID_SW));
        check("sw_imm_rd_en", 64'({id_imm, id_rd_en}), 64'({32'd4, 1'b0}));

        drive(1'b1, 32'hFFFF_FFFF, 32'h20C, 1'b1, 1'b0);
        check("ones_illegal", 64'({id_illegal, id_instID, jmp_vld}), 64'({1'b1, 8'd0, 1'b0}));
        drive(1'b1, 32'h0220_81B3, 32'h210, 1'b1, 1'b0);
        check("f7_illegal", 64'({id_illegal, id_instID, jmp_vld}), 64'({1'b1, 8'd0, 1'b0}));
        idle(1);

        // Four ADDIs under a 1,0,0,1 ex_ready pattern
        er_pat[0] = 1'b1; er_pat[1] = 1'b0; er_pat[2] = 1'b0; er_pat[3] = 1'b1;
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 40) begin
            er  = er_pat[cyc % 4];
            acc = (exp_q.size() == 0) || er;
            drive(1'b1, 32'h0000_0093 | (32'(idx + 1) << 20) | (32'(idx + 1) << 7),
                  32'h300 + 32'(4 * idx), er, 1'b0);
            if (acc) idx++;
            cyc++;
        end
        check("stream_accepted", 64'(idx), 64'd4);
        idle(2);

        // Flush while stalled drops both the held and the incoming word
        drive(1'b1, 32'h0090_0093, 32'h400, 1'b0, 1'b0);
        drive(1'b1, 32'h00A0_0093, 32'h404, 1'b0, 1'b1);
        check("flush_kills_held", 64'(id_valid), 64'd0);
        idle(1);
        check("flush_drops_incoming", 64'(id_valid), 64'd0);
        drive(1'b1, 32'h0080_00EF, 32'h500, 1'b1, 1'b1);
        check("flush_blocks_jal", 64'({id_valid, jmp_vld}), 64'd0);
        idle(1);

        // Randomized traffic
        inst = rand_inst();
        pc   = $urandom() & 32'hFFFF_FFFC;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            er = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 15) == 0);
            acc = v && (exp_q.size() == 0 || er) && !fl;
            drive(v, inst, pc, er, fl);
            if (acc || fl) begin
                inst = rand_inst();
                pc   = $urandom() & 32'hFFFF_FFFC;
            end
        end
        idle(2);

        // Asynchronous reset while a JAL is held and pulsing
        drive(1'b1, 32'h0080_00EF, 32'h600, 1'b1, 1'b0);
        n = 0;
        if_valid = 1'b0; ex_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid_jmp", 64'({id_valid, jmp_vld}), 64'd0);
        check("async_reset_data", 64'({id_imm, id_instID}), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 64'({id_valid, id_pc}), 64'd0);
        drive(1'b1, 32'h0050_0093, 32'h700, 1'b1, 1'b0);
        check("post_reset_decode", 64'({id_valid, id_instID, id_imm}), 64'({1'b1, ID_ADDI, 32'd5}));
        check("post_reset_pc", 64'(id_pc), 64'h700);
        idle(3);

        check("delivered_count", 64'(act_delivered.size()), 64'(exp_delivered.size()));
        n = (act_delivered.size() < exp_delivered.size()) ? act_delivered.size() : exp_delivered.size();
        for (int i = 0; i < n; i++) check("delivered_order", 64'(act_delivered[i]), 64'(exp_delivered[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
